// File: rtl/trig_pkg.sv
// Shared types and defaults for the trigger event recorder.
package trig_pkg;

    localparam int unsigned TRIG_DEPTH_DEF    = 16;
    localparam int unsigned TRIG_TS_WIDTH_DEF = 32;
    localparam int unsigned TRIGNUM_W         = 32;
    localparam int unsigned OVF_W             = 16;

    // Event layout for the default timestamp width; trigNum occupies the MSBs.
    typedef struct packed {
        logic [TRIGNUM_W-1:0]         trigNum;
        logic [TRIG_TS_WIDTH_DEF-1:0] timestamp;
    } trig_evt_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [OVF_W-1:0] sat_inc16(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trig_evt_fifo.sv
// First-word-fall-through event FIFO with exact registered occupancy count.
// A push is accepted while full only if the head is retired in the same cycle.
module trig_evt_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Decide push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != FULL_CNT) || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; left unreset because the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/trig_event_recorder.sv
// Trigger event recorder: stamps each accepted trigger with a running trigger
// number and timestamp, queues it, and counts triggers lost to a full queue.
module trig_event_recorder
    import trig_pkg::*;
#(
    parameter int unsigned DEPTH    = TRIG_DEPTH_DEF,
    parameter int unsigned TS_WIDTH = TRIG_TS_WIDTH_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          runStart,
    input  logic                          trigIn,
    output logic [TRIGNUM_W+TS_WIDTH-1:0] evtData,
    output logic                          evtValid,
    input  logic                          evtReady,
    output logic [$clog2(DEPTH):0]        fifoCount,
    output logic [OVF_W-1:0]              overflowCount
);

    logic [TS_WIDTH-1:0]  ts_q, ts_d, ts_evt;
    logic [TRIGNUM_W-1:0] tn_q, tn_d, tn_evt;
    logic [OVF_W-1:0]     ovf_q, ovf_d;
    logic                 fifo_full;
    logic                 drop;

    // Counter next-state; runStart zeroes the values the event is built from,
    // so a coincident trigger is recorded as trigNum=0, timestamp=0.
    always_comb begin
        ts_evt = runStart ? '0 : ts_q;
        tn_evt = runStart ? '0 : tn_q;
        ts_d   = runStart ? '0 : ts_q + 1'b1;
        tn_d   = tn_evt + {{(TRIGNUM_W-1){1'b0}}, trigIn};
        drop   = trigIn && fifo_full && !(evtValid && evtReady);
        ovf_d  = drop ? sat_inc16(ovf_q) : ovf_q;
    end

    // Timestamp, trigger number and overflow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q  <= '0;
            tn_q  <= '0;
            ovf_q <= '0;
        end else begin
            ts_q  <= ts_d;
            tn_q  <= tn_d;
            ovf_q <= ovf_d;
        end
    end

    trig_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRIGNUM_W + TS_WIDTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (trigIn),
        .pop_i   (evtReady),
        .wdata_i ({tn_evt, ts_evt}),
        .rdata_o (evtData),
        .valid_o (evtValid),
        .full_o  (fifo_full),
        .count_o (fifoCount)
    );

    assign overflowCount = ovf_q;

endmodule

// File: tb/tb_trig_event_recorder.sv
// Scoreboard bench for trig_event_recorder (32-bit timestamp instance plus an
// 8-bit timestamp instance for the wrap case).
module tb_trig_event_recorder;
    import trig_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic runStart = 1'b0, trigIn = 1'b0, evtReady = 1'b0;
    logic [63:0] evtData;
    logic        evtValid;
    logic [4:0]  fifoCount;
    logic [15:0] overflowCount;

    logic r8 = 1'b0, t8 = 1'b0, rdy8 = 1'b0;
    logic [39:0] evtData8;
    logic        evtValid8;
    logic [2:0]  fifoCount8;
    logic [15:0] ovf8;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] sb[$];
    logic [63:0] exp_q[$];
    logic [64:0] act_q[$];
    logic [31:0] m_ts, m_tn;
    int          m_ovf;

    always #5 clock = ~clock;

    trig_event_recorder #(.DEPTH(16), .TS_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .runStart(runStart), .trigIn(trigIn),
        .evtData(evtData), .evtValid(evtValid), .evtReady(evtReady),
        .fifoCount(fifoCount), .overflowCount(overflowCount)
    );

    trig_event_recorder #(.DEPTH(4), .TS_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .runStart(r8), .trigIn(t8),
        .evtData(evtData8), .evtValid(evtValid8), .evtReady(rdy8),
        .fifoCount(fifoCount8), .overflowCount(ovf8)
    );

    // One clock of the main instance: model the edge, then step past it.
    task automatic tick();
        logic do_pop, do_push;
        logic [31:0] tn_e, ts_e;
        do_pop  = (sb.size() > 0) && evtReady;
        do_push = trigIn && ((sb.size() < int'(DEPTH)) || do_pop);
        tn_e = runStart ? 32'd0 : m_tn;
        ts_e = runStart ? 32'd0 : m_ts;
        if (do_pop) begin
            exp_q.push_back(sb.pop_front());
            act_q.push_back({evtValid, evtData});
        end
        if (do_push) sb.push_back({tn_e, ts_e});
        else if (trigIn && m_ovf < 65535) m_ovf++;
        m_tn = tn_e + (trigIn ? 32'd1 : 32'd0);
        m_ts = runStart ? 32'd0 : m_ts + 32'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        sb.delete(); exp_q.delete(); act_q.delete();
        m_ts = '0; m_tn = '0; m_ovf = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (evtValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", evtValid); end
        tests_run++; if (fifoCount !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fifoCount); end
        tests_run++; if (overflowCount !== 16'd0) begin tests_failed++; $display("FAIL reset_ovf: got %0d want 0", overflowCount); end
        tests_run++; if (evtData !== 64'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", evtData); end
        tests_run++; if (evtValid8 !== 1'b0 || fifoCount8 !== 3'd0) begin tests_failed++; $display("FAIL reset_dut8: got v=%b c=%0d want v=0 c=0", evtValid8, fifoCount8); end
    endtask

    task automatic test_first_event();
        logic [64:0] a, e;
        evtReady = 1'b1;
        runStart = 1'b1; tick(); runStart = 1'b0;
        repeat (10) tick();
        tests_run++; if (fifoCount !== 5'd0) begin tests_failed++; $display("FAIL empty_ready_count: got %0d want 0", fifoCount); end
        tests_run++; if (evtValid !== 1'b0) begin tests_failed++; $display("FAIL empty_ready_valid: got %b want 0", evtValid); end
        trigIn = 1'b1; tick(); trigIn = 1'b0;
        tests_run++; if (evtValid !== 1'b1) begin tests_failed++; $display("FAIL first_latency: got %b want 1", evtValid); end
        tests_run++; if (fifoCount !== 5'd1) begin tests_failed++; $display("FAIL first_count: got %0d want 1", fifoCount); end
        tests_run++; if (evtData !== 64'h0000_0000_0000_000A) begin tests_failed++; $display("FAIL first_data: got %h want 000000000000000a", evtData); end
        tick();
        tests_run++; if (evtValid !== 1'b0 || fifoCount !== 5'd0) begin tests_failed++; $display("FAIL first_drained: got v=%b c=%0d want v=0 c=0", evtValid, fifoCount); end
        while (exp_q.size() > 0) begin
            e = {1'b1, exp_q.pop_front()}; a = act_q.pop_front();
            tests_run++; if (a !== e) begin tests_failed++; $display("FAIL first_sb: got %h want %h", a, e); end
        end
        evtReady = 1'b0;
    endtask

    task automatic test_overflow();
        evtReady = 1'b0;
        runStart = 1'b1; tick(); runStart = 1'b0;
        repeat (3) tick();
        trigIn = 1'b1;
        repeat (20) tick();
        trigIn = 1'b0;
        tests_run++; if (fifoCount !== 5'd16) begin tests_failed++; $display("FAIL ovf_count: got %0d want 16", fifoCount); end
        tests_run++; if (overflowCount !== 16'd4) begin tests_failed++; $display("FAIL ovf_drops: got %0d want 4", overflowCount); end
        tests_run++; if (evtValid !== 1'b1 || evtData !== 64'h0000_0000_0000_0003) begin tests_failed++; $display("FAIL ovf_head_stable: got v=%b d=%h want v=1 d=0000000000000003", evtValid, evtData); end
    endtask

    task automatic test_full_push_pop();
        logic [64:0] a, e;
        trig_evt_t ev;
        trigIn = 1'b1; evtReady = 1'b1; tick(); trigIn = 1'b0;
        tests_run++; if (fifoCount !== 5'd16) begin tests_failed++; $display("FAIL fullpp_count: got %0d want 16", fifoCount); end
        tests_run++; if (overflowCount !== 16'd4) begin tests_failed++; $display("FAIL fullpp_ovf: got %0d want 4", overflowCount); end
        repeat (16) tick();
        evtReady = 1'b0;
        tests_run++; if (fifoCount !== 5'd0) begin tests_failed++; $display("FAIL fullpp_drained: got %0d want 0", fifoCount); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = {1'b1, exp_q.pop_front()}; a = act_q.pop_front();
            ev = a[63:0];
            tests_run++; if (a !== e) begin tests_failed++; $display("FAIL fullpp_sb[%0d]: got %h want %h", i, a, e); end
            tests_run++;
            if (ev.trigNum !== ((i < 16) ? 32'(i) : 32'd20)) begin
                tests_failed++; $display("FAIL fullpp_order[%0d]: got %0d want %0d", i, ev.trigNum, (i < 16) ? i : 20);
            end
        end
    endtask

    task automatic test_run_and_trig();
        logic [64:0] a, e;
        evtReady = 1'b0;
        trigIn = 1'b1; repeat (2) tick(); trigIn = 1'b0; tick();
        runStart = 1'b1; trigIn = 1'b1; tick(); runStart = 1'b0; trigIn = 1'b0;
        repeat (3) tick();
        trigIn = 1'b1; tick(); trigIn = 1'b0;
        tests_run++; if (overflowCount !== 16'd4) begin tests_failed++; $display("FAIL run_keeps_ovf: got %0d want 4", overflowCount); end
        tests_run++; if (fifoCount !== 5'd4) begin tests_failed++; $display("FAIL run_keeps_fifo: got %0d want 4", fifoCount); end
        evtReady = 1'b1; repeat (4) tick(); evtReady = 1'b0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = {1'b1, exp_q.pop_front()}; a = act_q.pop_front();
            tests_run++; if (a !== e) begin tests_failed++; $display("FAIL run_sb[%0d]: got %h want %h", i, a, e); end
            if (i == 2) begin
                tests_run++; if (a[63:0] !== 64'h0) begin tests_failed++; $display("FAIL run_coincident: got %h want 0", a[63:0]); end
            end
            if (i == 3) begin
                tests_run++; if (a[63:0] !== 64'h0000_0001_0000_0003) begin tests_failed++; $display("FAIL run_next: got %h want 0000000100000003", a[63:0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [64:0] a, e;
        evtReady = 1'b0;
        trigIn = 1'b1; repeat (5) tick(); trigIn = 1'b0;
        tests_run++; if (fifoCount !== 5'd5) begin tests_failed++; $display("FAIL areset_pre: got %0d want 5", fifoCount); end
        #2 reset = 1'b1;
        model_clear();
        #1;
        tests_run++; if (evtValid !== 1'b0 || fifoCount !== 5'd0) begin tests_failed++; $display("FAIL areset_async: got v=%b c=%0d want v=0 c=0", evtValid, fifoCount); end
        tests_run++; if (overflowCount !== 16'd0 || evtData !== 64'd0) begin tests_failed++; $display("FAIL areset_clear: got ovf=%0d d=%h want 0 0", overflowCount, evtData); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) tick();
        trigIn = 1'b1; tick(); trigIn = 1'b0;
        evtReady = 1'b1; tick(); evtReady = 1'b0;
        tests_run++; if (exp_q.size() != 1) begin tests_failed++; $display("FAIL areset_pops: got %0d want 1", exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = {1'b1, exp_q.pop_front()}; a = act_q.pop_front();
            tests_run++; if (a !== e) begin tests_failed++; $display("FAIL areset_sb: got %h want %h", a, e); end
            tests_run++; if (a !== {1'b1, 64'h0000_0000_0000_0002}) begin tests_failed++; $display("FAIL areset_first: got %h want 1_0000000000000002", a); end
        end
    endtask

    task automatic test_ts_wrap();
        logic [7:0] exp_ts [3];
        exp_ts = '{8'd254, 8'd255, 8'd0};
        r8 = 1'b1; tick(); r8 = 1'b0;
        repeat (254) tick();
        t8 = 1'b1; repeat (3) tick(); t8 = 1'b0;
        tests_run++; if (fifoCount8 !== 3'd3) begin tests_failed++; $display("FAIL wrap_count: got %0d want 3", fifoCount8); end
        rdy8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (evtValid8 !== 1'b1 || evtData8 !== {32'(i), exp_ts[i]}) begin
                tests_failed++; $display("FAIL wrap_evt[%0d]: got v=%b d=%h want v=1 d=%h", i, evtValid8, evtData8, {32'(i), exp_ts[i]});
            end
            tick();
        end
        rdy8 = 1'b0;
        tests_run++; if (evtValid8 !== 1'b0) begin tests_failed++; $display("FAIL wrap_empty: got %b want 0", evtValid8); end
    endtask

    task automatic test_saturation();
        do_reset();
        evtReady = 1'b0;
        trigIn = 1'b1;
        repeat (16 + 65534) tick();
        tests_run++; if (overflowCount !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_below: got %h want fffe", overflowCount); end
        repeat (6) tick();
        trigIn = 1'b0;
        tests_run++; if (overflowCount !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h want ffff", overflowCount); end
        tests_run++; if (fifoCount !== 5'd16) begin tests_failed++; $display("FAIL sat_count: got %0d want 16", fifoCount); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_first_event();
        test_overflow();
        test_full_push_pop();
        test_run_and_trig();
        test_async_reset();
        test_ts_wrap();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
